// File: rtl/decimal_entry.sv
// decimal_entry: three-key signed decimal entry pad.
//
// Each raw pushbutton is synchronized, debounced and turned into a one-cycle
// press event. Digit presses build an unsigned magnitude (up to 7 BCD digits),
// the sign key toggles polarity, and enter commits the signed word to value,
// which is then held (value_valid) until the consumer acknowledges it.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   digit_in     BCD digit sampled on an accepted digit press
//   key_digit_n  raw active-low digit key
//   key_sign_n   raw active-low sign key
//   key_enter_n  raw active-low enter key
//   value        committed signed word
//   value_valid  value is held for the consumer
//   value_ack    consumer has taken value
//   entry_value  live signed echo of the entry in progress
//   digit_count  digits entered so far (0..7)
//   entry_err    one-cycle pulse on a rejected press
//
// state | meaning
// ------+----------------------------------------------------------
// ENTRY | accepting digit / sign / enter presses
// HOLD  | committed value held; presses rejected until value_ack

module decimal_entry #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  digit_in,
  input  logic        key_digit_n,
  input  logic        key_sign_n,
  input  logic        key_enter_n,
  output logic [31:0] value,
  output logic        value_valid,
  input  logic        value_ack,
  output logic [31:0] entry_value,
  output logic [2:0]  digit_count,
  output logic        entry_err
);

  localparam logic [15:0] CNT_TC = 16'(DEBOUNCE_CYCLES - 1);

  // key index: 0 = digit, 1 = sign, 2 = enter
  logic [2:0]  keys_n;
  logic [2:0]  sync1, sync2;
  logic [2:0]  db, db_d;
  logic [15:0] cnt [3];
  logic [2:0]  press;

  assign keys_n = {key_enter_n, key_sign_n, key_digit_n};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
      db    <= '1;
      db_d  <= '1;
      for (int k = 0; k < 3; k++) cnt[k] <= '0;
    end else begin
      sync1 <= keys_n;
      sync2 <= sync1;
      db_d  <= db;
      for (int k = 0; k < 3; k++) begin
        if (sync2[k] == db[k]) begin
          cnt[k] <= '0;
        end else if (cnt[k] == CNT_TC) begin
          // DEBOUNCE_CYCLES consecutive differing cycles seen
          db[k]  <= sync2[k];
          cnt[k] <= '0;
        end else begin
          cnt[k] <= cnt[k] + 16'd1;
        end
      end
    end
  end

  // falling edge of the debounced level = one press event
  assign press = db_d & ~db;

  logic ev_enter, ev_sign, ev_digit, ev_any;
  assign ev_enter = press[2];
  assign ev_sign  = press[1] & ~press[2];
  assign ev_digit = press[0] & ~press[1] & ~press[2];
  assign ev_any   = |press;

  typedef enum logic {ENTRY, HOLD} state_t;

  state_t      state, state_n;
  logic [23:0] mag, mag_n;
  logic        neg, neg_n;
  logic [2:0]  cnt_d_n;
  logic [31:0] value_n;
  logic        valid_n;
  logic        err_n;
  logic [31:0] mag_ext;
  logic [31:0] signed_mag;
  logic [23:0] mag_x10;

  assign mag_ext     = {8'd0, mag};
  assign signed_mag  = (neg && (mag != 24'd0)) ? (32'd0 - mag_ext) : mag_ext;
  assign entry_value = signed_mag;
  assign mag_x10     = {mag[20:0], 3'b000} + {mag[22:0], 1'b0};

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ENTRY;
      mag         <= '0;
      neg         <= 1'b0;
      digit_count <= '0;
      value       <= '0;
      value_valid <= 1'b0;
      entry_err   <= 1'b0;
    end else begin
      state       <= state_n;
      mag         <= mag_n;
      neg         <= neg_n;
      digit_count <= cnt_d_n;
      value       <= value_n;
      value_valid <= valid_n;
      entry_err   <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    mag_n   = mag;
    neg_n   = neg;
    cnt_d_n = digit_count;
    value_n = value;
    valid_n = value_valid;
    err_n   = 1'b0;
    case (state)
      ENTRY: begin
        if (ev_enter) begin
          value_n = signed_mag;
          valid_n = 1'b1;
          mag_n   = '0;
          neg_n   = 1'b0;
          cnt_d_n = '0;
          state_n = HOLD;
        end else if (ev_sign) begin
          neg_n = ~neg;
        end else if (ev_digit) begin
          if ((digit_in <= 4'd9) && (digit_count < 3'd7)) begin
            mag_n   = mag_x10 + {20'd0, digit_in};
            cnt_d_n = digit_count + 3'd1;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      HOLD: begin
        // ack wins over any coincident press; the press is still rejected
        if (value_ack) begin
          valid_n = 1'b0;
          state_n = ENTRY;
        end
        if (ev_any) err_n = 1'b1;
      end
      default: state_n = ENTRY;
    endcase
  end

endmodule
